mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Parametrised successor to the pipeline memory-access stage. It sits between the EX/MEM and MEM/WB pipeline registers and drives a request/grant/response data-memory port instead of a zero-latency array. It adds byte-lane steering with byte enables, RV64 widths (LD/SD/LWU), misalignment detection and a pipeline stall for multi-cycle memories.

## Interface
- XLEN, 32: datapath width; legal values are 32 and 64.
- NB, XLEN/8: byte lanes, derived; OFFW = log2(NB).

- clk  in  1  clock; all registers update on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ex_mem_valid  in  1  EX/MEM holds a real instruction.
- ex_mem_pc_4, ex_mem_alu_result, ex_mem_rs2_data  in  XLEN each  return PC, effective address, store data.
- ex_mem_rd  in  5;  ex_mem_funct3  in  3;  ex_mem_mem_write_en, ex_mem_mem_read_en, ex_mem_reg_write_en  in  1;  ex_mem_mem_to_reg_sel  in  2.
- mem_stall  out  1  combinational; freezes IF..EX/MEM while high.
- dmem_req  out  1;  dmem_we  out  1;  dmem_addr  out  XLEN (low OFFW bits zero);  dmem_be  out  NB;  dmem_wdata  out  XLEN.
- dmem_gnt  in  1  request accepted this cycle;  dmem_rvalid  in  1;  dmem_rdata  in  XLEN.
- mem_wb_valid, mem_wb_exc, mem_wb_reg_write_en  out  1;  mem_wb_pc_4, mem_wb_alu_result, mem_wb_mem_read_data  out  XLEN;  mem_wb_rd  out  5;  mem_wb_mem_to_reg_sel  out  2. All are registered.

## Operation
- access = ex_mem_valid & (read_en | write_en).
- Widths by funct3: 000/100 = 1 byte, 001/101 = 2 bytes, 010/110 = 4 bytes, 011 = 8 bytes.
- When XLEN=32, funct3 011 and 110 are illegal.
- exc = access & (illegal width | address offset not a multiple of the width). off = alu_result[OFFW-1:0].
- dmem_be = width mask << off. dmem_wdata = rs2_data << 8*off. dmem_we = write_en.
- Load data: lane = dmem_rdata >> 8*off, then extend by funct3:
  - 000 LB and 001 LH sign-extend.
  - 010 LW sign-extends on RV64.
  - 100 LBU, 101 LHU, 110 LWU zero-extend.
  - 011 LD passes through unchanged.
- FSM states IDLE, WAIT_GNT, WAIT_RSP:
  - IDLE: if access & !exc, drive dmem_req=1.
    - No gnt → WAIT_GNT.
    - gnt on a load → WAIT_RSP.
    - gnt on a store → completes, stay IDLE.
  - WAIT_GNT: hold dmem_req with the same request signals (inputs are stable because of the stall). On gnt, a load → WAIT_RSP and a store completes → IDLE.
  - WAIT_RSP: dmem_req=0. On dmem_rvalid, the load completes → IDLE.
  - dmem_rvalid in IDLE or WAIT_GNT is ignored.
- mem_stall = access & !exc & !complete, where complete = (store & gnt) | (WAIT_RSP & rvalid).
- MEM/WB update every edge:
  - Stalled: bubble, i.e. valid=0, reg_write_en=0, exc=0; data fields hold.
  - Not stalled: valid=ex_mem_valid, exc=exc, reg_write_en = ex_mem_reg_write_en & ex_mem_valid & !exc.
  - mem_read_data = extended load on a completing load, else 0. Remaining fields copy EX/MEM.
- An excepting access issues no request and causes no stall. It retires next edge with exc=1.

## Timing
- Reset (asynchronous): FSM → IDLE and every mem_wb_* output → 0. Combinational outputs follow the inputs; dmem_req is 0 in IDLE without an access.
- Reset asserted mid-access: the outstanding request is abandoned. A later rvalid is dropped in IDLE.
- Latency, counted from when the instruction is presented with zero-wait memory:
  - Non-memory op: MEM/WB valid at edge 1.
  - Store with gnt in the same cycle: no stall.
  - Load with gnt in the same cycle and rvalid next cycle: 1 stall cycle; MEM/WB valid at edge 2.
- Each gnt wait cycle adds one stall cycle. Each rvalid wait cycle adds one stall cycle.
- rvalid in the same cycle as gnt is not legal for this port. The memory returns data at least 1 cycle after gnt.
- Back-to-back accesses: the next access may request in the same cycle the previous one completes, because state is IDLE after the edge.

## Test plan
- Reset: assert rst asynchronously mid-cycle → all mem_wb_* are 0 immediately; dmem_req=0.
- SB, XLEN=32: addr 0x1003, rs2 0xAB → be=1000, wdata=0xAB000000, dmem_addr=0x1000. With gnt=1 → no stall; MEM/WB valid next edge.
- LH, XLEN=32: addr 0x2002, rdata 0x80010000, gnt held low 2 cycles, rvalid 1 cycle after gnt → mem_stall high 3 cycles, then mem_read_data=0xFFFF8001.
- LWU, XLEN=64: addr 0x...4, rdata 0xF000000100000000 → mem_read_data = 0x00000000F0000001.
- Misaligned LW at 0x1002, and LD with XLEN=32 → no dmem_req, no stall; mem_wb_exc=1, reg_write_en=0.
- Reset asserted during WAIT_RSP, then a stray rvalid → FSM stays IDLE; no MEM/WB write; next load completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// Pipeline memory-access stage with a request/grant/response data-memory port.
// Steers byte lanes, detects misaligned or illegal widths and stalls the pipe for slow memories.
module mem_access_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            ex_mem_valid,
    input  logic [XLEN-1:0] ex_mem_pc_4,
    input  logic [XLEN-1:0] ex_mem_alu_result,
    input  logic [XLEN-1:0] ex_mem_rs2_data,
    input  logic [4:0]      ex_mem_rd,
    input  logic [2:0]      ex_mem_funct3,
    input  logic            ex_mem_mem_write_en,
    input  logic            ex_mem_mem_read_en,
    input  logic            ex_mem_reg_write_en,
    input  logic [1:0]      ex_mem_mem_to_reg_sel,

    output logic            mem_stall,

    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN/8-1:0] dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,

    output logic            mem_wb_valid,
    output logic            mem_wb_exc,
    output logic            mem_wb_reg_write_en,
    output logic [XLEN-1:0] mem_wb_pc_4,
    output logic [XLEN-1:0] mem_wb_alu_result,
    output logic [XLEN-1:0] mem_wb_mem_read_data,
    output logic [4:0]      mem_wb_rd,
    output logic [1:0]      mem_wb_mem_to_reg_sel
);

    localparam int unsigned NB   = XLEN / 8;
    localparam int unsigned OFFW = $clog2(NB);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        WAIT_RSP
    } state_t;

    state_t state, state_nxt;

    logic            access;
    logic            is_load;
    logic            illegal;
    logic            misaligned;
    logic            exc;
    logic            complete;
    logic            load_done;
    logic [1:0]      size;
    logic [OFFW-1:0] off;
    logic [OFFW-1:0] align_mask;
    logic [NB-1:0]   width_mask;
    logic [XLEN-1:0] lane;
    logic [XLEN-1:0] load_ext;

    assign access  = ex_mem_valid & (ex_mem_mem_read_en | ex_mem_mem_write_en);
    assign is_load = ex_mem_mem_read_en;
    assign size    = ex_mem_funct3[1:0];
    assign off     = ex_mem_alu_result[OFFW-1:0];

    // Width legality: 111 is never a valid width; 8-byte and LWU need RV64.
    always_comb begin
        illegal = (ex_mem_funct3 == 3'b111);
        if (XLEN == 32 && (ex_mem_funct3 == 3'b011 || ex_mem_funct3 == 3'b110)) begin
            illegal = 1'b1;
        end
    end

    assign align_mask = OFFW'((4'd1 << size) - 4'd1);
    assign misaligned = |(off & align_mask);
    assign exc        = access & (illegal | misaligned);

    always_comb begin
        case (size)
            2'd0:    width_mask = NB'(8'h01);
            2'd1:    width_mask = NB'(8'h03);
            2'd2:    width_mask = NB'(8'h0F);
            default: width_mask = NB'(8'hFF);
        endcase
    end

    assign dmem_we    = ex_mem_mem_write_en;
    assign dmem_addr  = {ex_mem_alu_result[XLEN-1:OFFW], {OFFW{1'b0}}};
    assign dmem_be    = width_mask << off;
    assign dmem_wdata = ex_mem_rs2_data << {off, 3'b000};
    assign lane       = dmem_rdata >> {off, 3'b000};

    // Load extension: fill with the sign bit first, then overlay the loaded bytes.
    always_comb begin
        load_ext = '0;
        case (ex_mem_funct3)
            3'b000: begin
                load_ext      = {XLEN{lane[7]}};
                load_ext[7:0] = lane[7:0];
            end
            3'b001: begin
                load_ext       = {XLEN{lane[15]}};
                load_ext[15:0] = lane[15:0];
            end
            3'b010: begin
                load_ext       = {XLEN{lane[31]}};
                load_ext[31:0] = lane[31:0];
            end
            3'b100: load_ext[7:0]  = lane[7:0];
            3'b101: load_ext[15:0] = lane[15:0];
            3'b110: load_ext[31:0] = lane[31:0];
            default: load_ext = lane;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request sequencing; complete marks the cycle the access retires.
    always_comb begin
        state_nxt = state;
        dmem_req  = 1'b0;
        complete  = 1'b0;
        load_done = 1'b0;
        case (state)
            IDLE: begin
                if (access && !exc) begin
                    dmem_req = 1'b1;
                    if (!dmem_gnt) begin
                        state_nxt = WAIT_GNT;
                    end else if (is_load) begin
                        state_nxt = WAIT_RSP;
                    end else begin
                        complete = 1'b1;
                    end
                end
            end
            WAIT_GNT: begin
                dmem_req = 1'b1;
                if (dmem_gnt) begin
                    if (is_load) begin
                        state_nxt = WAIT_RSP;
                    end else begin
                        complete  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            WAIT_RSP: begin
                if (dmem_rvalid) begin
                    complete  = 1'b1;
                    load_done = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign mem_stall = access & ~exc & ~complete;

    // MEM/WB register: a stall inserts a bubble while data fields hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_wb_valid          <= 1'b0;
            mem_wb_exc            <= 1'b0;
            mem_wb_reg_write_en   <= 1'b0;
            mem_wb_pc_4           <= '0;
            mem_wb_alu_result     <= '0;
            mem_wb_mem_read_data  <= '0;
            mem_wb_rd             <= '0;
            mem_wb_mem_to_reg_sel <= '0;
        end else if (mem_stall) begin
            mem_wb_valid          <= 1'b0;
            mem_wb_exc            <= 1'b0;
            mem_wb_reg_write_en   <= 1'b0;
        end else begin
            mem_wb_valid          <= ex_mem_valid;
            mem_wb_exc            <= exc;
            mem_wb_reg_write_en   <= ex_mem_reg_write_en & ex_mem_valid & ~exc;
            mem_wb_pc_4           <= ex_mem_pc_4;
            mem_wb_alu_result     <= ex_mem_alu_result;
            mem_wb_mem_read_data  <= load_done ? load_ext : '0;
            mem_wb_rd             <= ex_mem_rd;
            mem_wb_mem_to_reg_sel <= ex_mem_mem_to_reg_sel;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: RV64 and RV32 instances checked against a transaction-level model.
module tb_mem_access_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        use32;
    logic        valid, re, we, rwe, gnt, rvalid;
    logic [63:0] pc4, alu, rs2, rdata;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [1:0]  msel;

    logic        d64_stall, d64_req, d64_we, d64_valid, d64_exc, d64_rwe;
    logic [63:0] d64_addr, d64_wdata, d64_pc4, d64_alu, d64_rdata;
    logic [7:0]  d64_be;
    logic [4:0]  d64_rd;
    logic [1:0]  d64_sel;

    logic        d32_stall, d32_req, d32_we, d32_valid, d32_exc, d32_rwe;
    logic [31:0] d32_addr, d32_wdata, d32_pc4, d32_alu, d32_rdata;
    logic [3:0]  d32_be;
    logic [4:0]  d32_rd;
    logic [1:0]  d32_sel;

    mem_access_unit #(.XLEN(64)) u_d64 (
        .clk(clk), .rst(rst),
        .ex_mem_valid(valid & ~use32), .ex_mem_pc_4(pc4), .ex_mem_alu_result(alu),
        .ex_mem_rs2_data(rs2), .ex_mem_rd(rd), .ex_mem_funct3(f3),
        .ex_mem_mem_write_en(we), .ex_mem_mem_read_en(re), .ex_mem_reg_write_en(rwe),
        .ex_mem_mem_to_reg_sel(msel), .mem_stall(d64_stall),
        .dmem_req(d64_req), .dmem_we(d64_we), .dmem_addr(d64_addr), .dmem_be(d64_be),
        .dmem_wdata(d64_wdata), .dmem_gnt(gnt & ~use32), .dmem_rvalid(rvalid & ~use32),
        .dmem_rdata(rdata),
        .mem_wb_valid(d64_valid), .mem_wb_exc(d64_exc), .mem_wb_reg_write_en(d64_rwe),
        .mem_wb_pc_4(d64_pc4), .mem_wb_alu_result(d64_alu), .mem_wb_mem_read_data(d64_rdata),
        .mem_wb_rd(d64_rd), .mem_wb_mem_to_reg_sel(d64_sel)
    );

    mem_access_unit #(.XLEN(32)) u_d32 (
        .clk(clk), .rst(rst),
        .ex_mem_valid(valid & use32), .ex_mem_pc_4(pc4[31:0]), .ex_mem_alu_result(alu[31:0]),
        .ex_mem_rs2_data(rs2[31:0]), .ex_mem_rd(rd), .ex_mem_funct3(f3),
        .ex_mem_mem_write_en(we), .ex_mem_mem_read_en(re), .ex_mem_reg_write_en(rwe),
        .ex_mem_mem_to_reg_sel(msel), .mem_stall(d32_stall),
        .dmem_req(d32_req), .dmem_we(d32_we), .dmem_addr(d32_addr), .dmem_be(d32_be),
        .dmem_wdata(d32_wdata), .dmem_gnt(gnt & use32), .dmem_rvalid(rvalid & use32),
        .dmem_rdata(rdata[31:0]),
        .mem_wb_valid(d32_valid), .mem_wb_exc(d32_exc), .mem_wb_reg_write_en(d32_rwe),
        .mem_wb_pc_4(d32_pc4), .mem_wb_alu_result(d32_alu), .mem_wb_mem_read_data(d32_rdata),
        .mem_wb_rd(d32_rd), .mem_wb_mem_to_reg_sel(d32_sel)
    );

    // Observed view of whichever instance is active, widened to 64 bits.
    logic        ob_stall, ob_req, ob_we, ob_valid, ob_exc, ob_rwe;
    logic [63:0] ob_addr, ob_wdata, ob_pc4, ob_alu, ob_rdata;
    logic [7:0]  ob_be;
    logic [4:0]  ob_rd;
    logic [1:0]  ob_sel;

    always_comb begin
        if (use32) begin
            ob_stall = d32_stall; ob_req = d32_req; ob_we = d32_we;
            ob_valid = d32_valid; ob_exc = d32_exc; ob_rwe = d32_rwe;
            ob_addr = 64'(d32_addr); ob_wdata = 64'(d32_wdata); ob_be = 8'(d32_be);
            ob_pc4 = 64'(d32_pc4); ob_alu = 64'(d32_alu); ob_rdata = 64'(d32_rdata);
            ob_rd = d32_rd; ob_sel = d32_sel;
        end else begin
            ob_stall = d64_stall; ob_req = d64_req; ob_we = d64_we;
            ob_valid = d64_valid; ob_exc = d64_exc; ob_rwe = d64_rwe;
            ob_addr = d64_addr; ob_wdata = d64_wdata; ob_be = d64_be;
            ob_pc4 = d64_pc4; ob_alu = d64_alu; ob_rdata = d64_rdata;
            ob_rd = d64_rd; ob_sel = d64_sel;
        end
    end

    int checks = 0;
    int errors = 0;

    // Expected MEM/WB contents
    logic        e_valid, e_exc, e_rwe;
    logic [63:0] e_pc4, e_alu, e_rdata;
    logic [4:0]  e_rd;
    logic [1:0]  e_sel;
    logic        cur_exc;
    int          stall_cnt;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t xlen=%0d)", nm, act, exp, $time, use32 ? 32 : 64);
        end
    endtask

    function automatic int xl();
        return use32 ? 32 : 64;
    endfunction

    function automatic logic [63:0] xmask();
        return use32 ? 64'h0000_0000_FFFF_FFFF : '1;
    endfunction

    function automatic int wbytes(input logic [2:0] f);
        return 1 << f[1:0];
    endfunction

    function automatic int offset(input logic [63:0] a);
        return int'(a[2:0]) & (xl() / 8 - 1);
    endfunction

    function automatic bit is_exc(input logic [2:0] f, input logic [63:0] a);
        bit ill;
        ill = (f == 3'b111) || (use32 && (f == 3'b011 || f == 3'b110));
        return ill || ((a & 64'(wbytes(f) - 1)) != 64'd0);
    endfunction

    function automatic logic [63:0] exp_load(input logic [2:0] f, input logic [63:0] a, input logic [63:0] d);
        logic [63:0] lane, m, v;
        int w;
        w    = wbytes(f);
        lane = (d & xmask()) >> (8 * offset(a));
        if (f == 3'b011) begin
            v = lane;
        end else begin
            m = (64'd1 << (8 * w)) - 64'd1;
            v = lane & m;
            if (!f[2] && w < xl() / 8 && lane[8 * w - 1]) v = v | ~m;
        end
        return v & xmask();
    endfunction

    function automatic logic [7:0] exp_be(input logic [2:0] f, input logic [63:0] a);
        logic [15:0] t;
        t = ((16'd1 << wbytes(f)) - 16'd1) << offset(a);
        return t[7:0];
    endfunction

    task automatic model_reset();
        e_valid = 0; e_exc = 0; e_rwe = 0;
        e_pc4 = '0; e_alu = '0; e_rdata = '0; e_rd = '0; e_sel = '0;
    endtask

    task automatic chk_mem_wb();
        chk("wb_valid", 64'(ob_valid), 64'(e_valid));
        chk("wb_exc", 64'(ob_exc), 64'(e_exc));
        chk("wb_rwe", 64'(ob_rwe), 64'(e_rwe));
        chk("wb_pc4", ob_pc4, e_pc4);
        chk("wb_alu", ob_alu, e_alu);
        chk("wb_rdata", ob_rdata, e_rdata);
        chk("wb_rd", 64'(ob_rd), 64'(e_rd));
        chk("wb_sel", 64'(ob_sel), 64'(e_sel));
    endtask

    // One cycle: combinational checks mid-cycle, registered checks just after the edge.
    task automatic step(input bit e_req, input bit e_stall, input bit ld_done, input logic [63:0] ld_val);
        #1;
        chk("dmem_req", 64'(ob_req), 64'(e_req));
        chk("mem_stall", 64'(ob_stall), 64'(e_stall));
        if (e_req) begin
            chk("dmem_we", 64'(ob_we), 64'(we));
            chk("dmem_addr", ob_addr, alu & xmask() & ~64'(xl() / 8 - 1));
            chk("dmem_be", 64'(ob_be), 64'(exp_be(f3, alu)));
            chk("dmem_wdata", ob_wdata, (rs2 << (8 * offset(alu))) & xmask());
        end
        if (ob_stall) stall_cnt++;
        @(posedge clk);
        #1;
        if (e_stall) begin
            e_valid = 0; e_exc = 0; e_rwe = 0;
        end else begin
            e_valid = valid;
            e_exc   = cur_exc;
            e_rwe   = valid & rwe & ~cur_exc;
            e_pc4   = pc4 & xmask();
            e_alu   = alu & xmask();
            e_rdata = ld_done ? ld_val : 64'd0;
            e_rd    = rd;
            e_sel   = msel;
        end
        chk_mem_wb();
        @(negedge clk);
    endtask

    // Present one instruction and play the memory side with gw grant waits and rw response waits.
    task automatic run_op(input logic v, input logic r, input logic w, input logic f_rwe,
                          input logic [2:0] f, input logic [63:0] a, input logic [63:0] d,
                          input int gw, input int rw, input logic [63:0] rdf,
                          output int stalls, output logic [63:0] got);
        bit acc;
        valid = v; re = r; we = w; rwe = f_rwe; f3 = f; alu = a; rs2 = d;
        pc4 = {$urandom, $urandom}; rd = 5'($urandom); msel = 2'($urandom);
        acc = v && (r || w);
        cur_exc = acc && is_exc(f, a);
        stall_cnt = 0;
        if (!acc || cur_exc) begin
            gnt = 1'($urandom); rvalid = 1'($urandom); rdata = {$urandom, $urandom};
            step(0, 0, 0, 64'd0);
        end else begin
            for (int i = 0; i < gw; i++) begin
                gnt = 0; rvalid = 1'($urandom); rdata = {$urandom, $urandom};
                step(1, 1, 0, 64'd0);
            end
            gnt = 1; rvalid = 0;
            if (!r) begin
                step(1, 0, 0, 64'd0);
            end else begin
                step(1, 1, 0, 64'd0);
                gnt = 0;
                for (int i = 0; i < rw; i++) begin
                    rdata = {$urandom, $urandom};
                    step(0, 1, 0, 64'd0);
                end
                rvalid = 1; rdata = rdf;
                step(0, 0, 1, exp_load(f, a, rdf));
            end
        end
        gnt = 0; rvalid = 0;
        stalls = stall_cnt;
        got = ob_rdata;
    endtask

    task automatic reset_pulse();
        valid = 0; gnt = 0; rvalid = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    task automatic random_ops(input int n);
        int st, t, r, w;
        logic [63:0] got, a;
        logic [2:0] f;
        for (int i = 0; i < n; i++) begin
            t = int'($urandom % 4);
            r = (t == 1 || t == 3) ? 1 : 0;
            w = (t == 2) ? 1 : 0;
            f = 3'($urandom);
            a = {$urandom, $urandom};
            if ($urandom % 4 != 0) a = a & ~64'(wbytes(f) - 1);
            run_op(($urandom % 10) != 0, 1'(r), 1'(w), 1'($urandom), f, a, {$urandom, $urandom},
                   int'($urandom % 4), int'($urandom % 4), {$urandom, $urandom}, st, got);
        end
    endtask

    initial begin
        int st;
        logic [63:0] got;
        rst = 0; use32 = 0; valid = 0; re = 0; we = 0; rwe = 0; gnt = 0; rvalid = 0;
        pc4 = '0; alu = '0; rs2 = '0; rdata = '0; rd = '0; f3 = '0; msel = '0; cur_exc = 0;
        model_reset();

        // Asynchronous reset mid-cycle
        @(negedge clk);
        #2 rst = 1;
        #1;
        chk_mem_wb();
        chk("rst_req", 64'(ob_req), 64'd0);
        @(negedge clk);
        rst = 0;

        // ---------------- RV64 ----------------
        run_op(1, 1, 0, 1, 3'b110, 64'h0000_0000_8000_0004, 64'd0, 0, 1,
               64'hF000_0001_0000_0000, st, got);
        chk("lwu_data", got, 64'h0000_0000_F000_0001);
        chk("lwu_stalls", 64'(st), 64'd2);
        random_ops(300);

        // Reset while waiting for a load response, then a stray rvalid
        valid = 1; re = 1; we = 0; rwe = 1; f3 = 3'b011; alu = 64'h100; cur_exc = 0;
        stall_cnt = 0; gnt = 1; rvalid = 0;
        step(1, 1, 0, 64'd0);
        gnt = 0;
        #2 valid = 0; rst = 1;
        #1;
        model_reset();
        chk_mem_wb();
        chk("rst_mid_req", 64'(ob_req), 64'd0);
        @(negedge clk);
        rst = 0;
        cur_exc = 0; rvalid = 1; rdata = {$urandom, $urandom};
        step(0, 0, 0, 64'd0);
        chk("stray_rvalid_valid", 64'(ob_valid), 64'd0);
        rvalid = 0;
        run_op(1, 1, 0, 1, 3'b011, 64'h108, 64'd0, 1, 1, 64'h0123_4567_89AB_CDEF, st, got);
        chk("ld_after_rst", got, 64'h0123_4567_89AB_CDEF);
        chk("ld_after_rst_stalls", 64'(st), 64'd3);

        // ---------------- RV32 ----------------
        reset_pulse();
        use32 = 1;
        @(negedge clk);
        valid = 1; re = 0; we = 1; f3 = 3'b000; alu = 64'h1003; rs2 = 64'hAB;
        #1;
        chk("sb_be", 64'(ob_be), 64'h8);
        chk("sb_wdata", ob_wdata, 64'hAB00_0000);
        chk("sb_addr", ob_addr, 64'h1000);
        run_op(1, 0, 1, 0, 3'b000, 64'h1003, 64'hAB, 0, 0, 64'd0, st, got);
        chk("sb_stalls", 64'(st), 64'd0);
        chk("sb_wb_valid", 64'(ob_valid), 64'd1);

        run_op(1, 1, 0, 1, 3'b001, 64'h2002, 64'd0, 2, 0, 64'h8001_0000, st, got);
        chk("lh_stalls", 64'(st), 64'd3);
        chk("lh_data", got, 64'hFFFF_8001);

        run_op(1, 1, 0, 1, 3'b010, 64'h1002, 64'd0, 0, 0, 64'd0, st, got);
        chk("lw_mis_exc", 64'(ob_exc), 64'd1);
        chk("lw_mis_rwe", 64'(ob_rwe), 64'd0);
        chk("lw_mis_stalls", 64'(st), 64'd0);

        run_op(1, 1, 0, 1, 3'b011, 64'h1000, 64'd0, 0, 0, 64'd0, st, got);
        chk("ld32_exc", 64'(ob_exc), 64'd1);
        chk("ld32_rwe", 64'(ob_rwe), 64'd0);
        chk("ld32_stalls", 64'(st), 64'd0);

        random_ops(300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
